// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer.
// SHIFT_SEQ_PARITY_EN adds the PARITY state to the state enum.
package shift_seq_pkg;

    localparam int unsigned DefaultWidth = 8;

    localparam logic ModeTx = 1'b0;
    localparam logic ModeRx = 1'b1;

`ifdef SHIFT_SEQ_PARITY_EN
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StParity = 2'd2,
        StDone   = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd3
    } state_e;
`endif

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Handshake and data bundle between a transfer requester (master) and the
// shift sequencer (slave).
interface shift_seq_ctrl_if #(
    parameter int unsigned WIDTH = shift_seq_pkg::DefaultWidth
);
    logic             start;
    logic             mode;
    logic             abort;
    logic [WIDTH-1:0] data_in;
    logic             serialIn;
    logic             serialOut;
    logic [WIDTH-1:0] paralellOut;
    logic             busy;
    logic             done;
    logic             parity_err;

    modport master (
        output start, mode, abort, data_in, serialIn,
        input  serialOut, paralellOut, busy, done, parity_err
    );

    modport slave (
        input  start, mode, abort, data_in, serialIn,
        output serialOut, paralellOut, busy, done, parity_err
    );
endinterface

// File: rtl/shift_reg_core.sv
// Loadable bidirectional shift register; dir=0 shifts toward bit 0 (LSB out
// first), dir=1 shifts toward the MSB (MSB out first).
module shift_reg_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             dir,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    output logic             sout,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] reg_d, reg_q;

    always_comb begin
        reg_d = reg_q;
        if (load) begin
            reg_d = din;
        end else if (shift) begin
            reg_d = dir ? {reg_q[WIDTH-2:0], sin} : {sin, reg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign sout = dir ? reg_q[WIDTH-1] : reg_q[0];
    assign q    = reg_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift sequencer: FSM and bit counter driving shift_reg_core for one
// transmit or receive transfer. SHIFT_SEQ_PARITY_EN adds an even-parity bit.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    shift_seq_ctrl_if.slave bus
);

    localparam int unsigned    CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic             mode_q;
    logic [WIDTH-1:0] par_q;
    logic             busy_q;
    logic             done_q;
    logic             serial_out;

    logic             load;
    logic             shift_en;
    logic [WIDTH-1:0] din;
    logic             sin;
    logic             sout;
    logic [WIDTH-1:0] reg_q;

    // Transmit recirculates sout so the register holds the sent word at the end.
    always_comb begin
        load     = (state_q == StIdle) && bus.start && !bus.abort;
        shift_en = (state_q == StShift) && !bus.abort;
        din      = (bus.mode == ModeTx) ? bus.data_in : '0;
        sin      = (mode_q == ModeTx) ? sout : bus.serialIn;
    end

    function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] v, input logic b);
        if (MSB_FIRST) begin
            return {v[WIDTH-2:0], b};
        end
        return {b, v[WIDTH-1:1]};
    endfunction

    shift_reg_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .shift(shift_en),
        .dir  (MSB_FIRST),
        .din  (din),
        .sin  (sin),
        .sout (sout),
        .q    (reg_q)
    );

`ifdef SHIFT_SEQ_PARITY_EN
    logic perr_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mode_q  <= ModeTx;
            par_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start && !bus.abort) begin
                        state_q <= StShift;
                        cnt_q   <= '0;
                        mode_q  <= bus.mode;
                        busy_q  <= 1'b1;
`ifdef SHIFT_SEQ_PARITY_EN
                        perr_q  <= 1'b0;
`endif
                    end
                end
                StShift: begin
                    if (bus.abort) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == LastCnt) begin
`ifdef SHIFT_SEQ_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            par_q   <= shifted(reg_q, sin);
`endif
                        end
                    end
                end
`ifdef SHIFT_SEQ_PARITY_EN
                StParity: begin
                    if (bus.abort) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        par_q   <= reg_q;
                        if (mode_q == ModeRx) begin
                            perr_q <= bus.serialIn ^ (^reg_q);
                        end
                    end
                end
`endif
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        serial_out = 1'b0;
        if (mode_q == ModeTx) begin
            if (state_q == StShift) begin
                serial_out = sout;
            end
`ifdef SHIFT_SEQ_PARITY_EN
            if (state_q == StParity) begin
                serial_out = ^reg_q;
            end
`endif
        end
    end

    assign bus.serialOut   = serial_out;
    assign bus.paralellOut = par_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
`ifdef SHIFT_SEQ_PARITY_EN
    assign bus.parity_err  = perr_q;
`else
    assign bus.parity_err  = 1'b0;
`endif

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: shift register length in bits, range 2..16.
REQ-002 Parameter MSB_FIRST, default 0: 0 shifts LSB first, 1 shifts MSB first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request one transfer; sampled only in IDLE.
REQ-006 mode  input  1  0 = transmit (parallel-to-serial), 1 = receive (serial-to-parallel); captured with start.
REQ-007 abort  input  1  synchronous cancel of the current transfer.
REQ-008 data_in  input  WIDTH  transmit word; captured with start.
REQ-009 serialIn  input  1  receive serial bit, sampled once per SHIFT cycle.
REQ-010 serialOut  output  1  transmit serial bit.
REQ-011 paralellOut  output  WIDTH  received word, or the transmitted word after a transmit.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at the end of a transfer.
REQ-014 parity_err  output  1  receive parity mismatch flag.

Function
REQ-015 The FSM SHALL have the states IDLE, SHIFT, PARITY (present only with PARITY_EN) and DONE.
REQ-016 IDLE with start=1 and abort=0 SHALL go to SHIFT, load the register (data_in for transmit, all zeros for receive), clear the bit counter and latch mode.
REQ-017 SHIFT SHALL shift exactly one bit per cycle, increment the counter, and leave after WIDTH cycles: to PARITY if enabled, otherwise to DONE.
REQ-018 In transmit, serialOut SHALL present bit k (in MSB_FIRST order) during SHIFT cycle k; outside SHIFT and PARITY, serialOut SHALL be 0.
REQ-019 In receive, serialIn sampled in SHIFT cycle k SHALL land at bit position k (in MSB_FIRST order) of paralellOut.
REQ-020 DONE SHALL assert done for exactly one cycle, hold paralellOut stable, and return to IDLE.
REQ-021 Latency: start accepted at edge N; data bits occupy cycles N+1..N+WIDTH; done is high in cycle N+WIDTH+1, or N+WIDTH+2 with parity.
REQ-022 start while busy SHALL be ignored, not queued.
REQ-023 abort in any non-IDLE state SHALL return the FSM to IDLE next cycle without a done pulse; paralellOut SHALL keep its last completed value.
REQ-024 abort and start high together in IDLE: abort wins and no transfer starts.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap during a transfer.
REQ-026 paralellOut SHALL update only on entry to DONE.

Reset
REQ-027 reset low SHALL force, immediately: state IDLE, counter 0, register 0, paralellOut 0, serialOut 0, busy 0, done 0, parity_err 0.
REQ-028 reset mid-transfer SHALL discard the transfer; no done pulse follows.

Configuration
REQ-029 The macro SHIFT_SEQ_PARITY_EN, when defined, SHALL add the PARITY state: transmit drives the even-parity bit of the word on serialOut; receive samples serialIn, and parity_err is set in DONE on mismatch and cleared on the next accepted start.
REQ-030 Without SHIFT_SEQ_PARITY_EN: no PARITY state, and parity_err is tied to 0.

Structure
REQ-031 A shared package shift_seq_pkg SHALL hold the state enum typedef, the mode encoding constants and the default WIDTH.
REQ-032 The shift register datapath SHALL be a separate sub-module shift_reg_core, with ports load, shift, dir, din, sin, sout and q; the FSM and counter live in shift_seq_ctrl.

Verification
REQ-033 Transmit: WIDTH=8, LSB first, data_in=8'hA5 -> serialOut 1,0,1,0,0,1,0,1 in cycles N+1..N+8; done in cycle N+9; paralellOut=8'hA5.
REQ-034 Receive: serialIn 0,1,1,0,0,0,1,1 (LSB first) -> paralellOut=8'hC6; done in cycle N+9.
REQ-035 Abort at SHIFT cycle 4 -> busy low next cycle; no done pulse; paralellOut unchanged; a following start runs normally.
REQ-036 start pulsed during SHIFT -> ignored; exactly one done pulse per accepted start.
REQ-037 reset driven low mid-receive between clock edges -> all outputs 0 immediately; no done pulse after release.
REQ-038 SHIFT_SEQ_PARITY_EN defined, receive 8'hC6 with parity bit 1 -> parity_err=1 in cycle N+10; repeat with parity bit 0 -> parity_err=0.
